// File: rtl/htc_weight_readback.sv
// Streams HTC weight BRAM rows to the host over AXI-Stream, one row per beat.
// Optional trailing checksum beat is built in when HTC_READBACK_CHECKSUM_EN is defined.
module htc_weight_readback #(
  parameter int D_PADDED   = 192,
  parameter int R          = 2048,
  parameter int AXI_WIDTH  = 512,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_full_dump,
  input  logic [$clog2(R)-1:0]  cmd_start,
  input  logic [$clog2(R):0]    cmd_count,
  output logic [$clog2(R)-1:0]  bram_raddr,
  output logic                  bram_re,
  input  logic [D_PADDED-1:0]   bram_rdata,
  output logic [AXI_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [63:0]           m_axis_tuser,
  output logic                  busy,
  output logic [31:0]           beats_sent,
  output logic                  dump_done
);
  localparam int AW    = $clog2(R);
  localparam int DEPTH = RD_LATENCY + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef HTC_READBACK_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
`endif

  typedef struct packed {
    logic [D_PADDED-1:0] data;
    logic [AW-1:0]       id;
    logic                last;
  } entry_t;

  state_t state, state_n;

  logic [AW-1:0]  addr;
  logic [AW:0]    remaining;
  logic           full_flag;
  logic [CW-1:0]  outstanding;

  logic [RD_LATENCY:1]         vld_pipe;
  logic [RD_LATENCY:1]         last_pipe;
  logic [RD_LATENCY:1][AW-1:0] id_pipe;

  entry_t         fifo [DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  fifo_cnt;
  entry_t         head;

  logic cmd_fire, zero_cmd, issue, push, row_pop, beat_fire, tlast_fire;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cmd_fire   = cmd_ready && cmd_valid;
  assign zero_cmd   = !cmd_full_dump && (cmd_count == '0);
  // Outstanding counts reads in flight plus FIFO occupancy, so capping it at
  // the FIFO depth guarantees every returning read has a slot.
  assign issue      = (state == ISSUE) && (outstanding < CW'(DEPTH));
  assign push       = vld_pipe[RD_LATENCY];
  assign head       = fifo[rd_ptr];
  assign row_pop    = (fifo_cnt != '0) && m_axis_tready;
  assign beat_fire  = m_axis_tvalid && m_axis_tready;
  assign tlast_fire = beat_fire && m_axis_tlast;
  assign bram_re    = issue;
  assign bram_raddr = addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_fire && !zero_cmd) state_n = ISSUE;
      ISSUE:   if (issue && remaining == (AW+1)'(1)) state_n = DRAIN;
`ifdef HTC_READBACK_CHECKSUM_EN
      DRAIN:   if (row_pop && head.last) state_n = CSUM;
      CSUM:    if (m_axis_tready) state_n = IDLE;
`else
      DRAIN:   if (row_pop && head.last) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      full_flag   <= 1'b0;
      outstanding <= '0;
      vld_pipe    <= '0;
      last_pipe   <= '0;
      id_pipe     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      beats_sent  <= '0;
      dump_done   <= 1'b0;
    end else begin
      state     <= state_n;
      dump_done <= (cmd_fire && zero_cmd) || tlast_fire;

      if (cmd_fire) begin
        addr      <= cmd_full_dump ? '0 : cmd_start;
        remaining <= cmd_full_dump ? (AW+1)'(R) : cmd_count;
        full_flag <= cmd_full_dump;
      end else if (issue) begin
        addr      <= addr + AW'(1);
        remaining <= remaining - (AW+1)'(1);
      end

      outstanding <= outstanding + CW'(issue) - CW'(row_pop);

      // Row id and last-row tag travel alongside the BRAM read latency.
      vld_pipe  <= RD_LATENCY'({vld_pipe, issue});
      last_pipe <= RD_LATENCY'({last_pipe, remaining == (AW+1)'(1)});
      id_pipe   <= (RD_LATENCY*AW)'({id_pipe, addr});

      if (push)    wr_ptr <= ptr_inc(wr_ptr);
      if (row_pop) rd_ptr <= ptr_inc(rd_ptr);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(row_pop);

      if (beat_fire) beats_sent <= beats_sent + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{data: bram_rdata, id: id_pipe[RD_LATENCY], last: last_pipe[RD_LATENCY]};
  end

`ifdef HTC_READBACK_CHECKSUM_EN
  logic [63:0] csum, row_fold;

  always_comb begin
    row_fold = '0;
    for (int w = 0; w < D_PADDED / 64; w++) row_fold ^= head.data[w*64 +: 64];
  end

  always_ff @(posedge clk) begin
    if (rst || cmd_fire) csum <= '0;
    else if (row_pop)    csum <= csum ^ row_fold;
  end
`else
  // Plain build: the final row beat carries tlast and tuser[17] stays 0.
`endif

  always_comb begin
    m_axis_tvalid = (fifo_cnt != '0);
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    if (fifo_cnt != '0) begin
      m_axis_tdata[D_PADDED-1:0] = head.data;
      m_axis_tuser[15:0]         = 16'(head.id);
      m_axis_tuser[16]           = full_flag;
`ifdef HTC_READBACK_CHECKSUM_EN
      m_axis_tlast               = 1'b0;
`else
      m_axis_tlast               = head.last;
`endif
    end
`ifdef HTC_READBACK_CHECKSUM_EN
    if (state == CSUM) begin
      m_axis_tvalid      = 1'b1;
      m_axis_tdata[63:0] = csum;
      m_axis_tuser[17]   = 1'b1;
      m_axis_tuser[16]   = full_flag;
      m_axis_tlast       = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_htc_weight_readback.sv
// Self-checking bench for htc_weight_readback: vector table of dumps plus scoreboard,
// and hand sequences for zero-count, reset mid-dump and the checksum beat.
module tb_htc_weight_readback;
  localparam int D   = 192;
  localparam int R   = 2048;
  localparam int AXW = 512;
  localparam int L   = 1;
  localparam int AW  = 11;
`ifdef HTC_READBACK_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_full_dump = 1'b0;
  logic [AW-1:0]  cmd_start = '0;
  logic [AW:0]    cmd_count = '0;
  logic [AW-1:0]  bram_raddr;
  logic           bram_re;
  logic [D-1:0]   bram_rdata = '0;
  logic [AXW-1:0] m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic           m_axis_tlast;
  logic [63:0]    m_axis_tuser;
  logic           busy;
  logic [31:0]    beats_sent;
  logic           dump_done;

  htc_weight_readback #(.D_PADDED(D), .R(R), .AXI_WIDTH(AXW), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_full_dump(cmd_full_dump),
    .cmd_start(cmd_start), .cmd_count(cmd_count),
    .bram_raddr(bram_raddr), .bram_re(bram_re), .bram_rdata(bram_rdata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .beats_sent(beats_sent), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [D-1:0] data;
    logic [15:0]  id;
    logic         full;
    logic         last;
    logic         csum;
  } beat_t;

  typedef struct {
    bit full;
    int start;
    int count;
    bit rnd;
    int exp_beats;
    int exp_first;
    int exp_last;
  } vec_t;

  beat_t       sb[$];
  vec_t        vecs[6];
  int          vectors = 0;
  int          miscompares = 0;
  int          pat = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  bit          first_pend = 0;
  int          out_model = 0;
  int          done_cnt = 0;
  int          dump_beats = 0;
  int          first_id = 0;
  int          last_row_id = 0;
  logic [63:0] last_csum = '0;
  bit          seen100 = 0;
  logic [31:0] exp_sent = '0;
  bit          stall_prev = 0;
  logic [AXW-1:0] hold_data;
  logic [63:0] hold_user;
  logic        hold_last;

  function automatic logic [D-1:0] row_fn(input int i);
    logic [15:0] id16;
    id16 = 16'(i);
    if (pat == 1) return (i < 4) ? (D'(1) << i) : '0;
    return {12{id16}};
  endfunction

  // BRAM model, one-cycle read latency
  always @(posedge clk) if (bram_re) bram_rdata <= row_fn(int'(bram_raddr));
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [AXW-1:0] act, input logic [AXW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input bit full, input int start, input int count);
    logic [63:0] cs;
    beat_t b;
    int rid;
    cs = '0;
    for (int k = 0; k < count; k++) begin
      rid    = (start + k) % R;
      b.data = row_fn(rid);
      b.id   = 16'(rid);
      b.full = full;
      b.csum = 1'b0;
      b.last = (k == count - 1) && (CS == 0);
      for (int w = 0; w < D / 64; w++) cs ^= b.data[w*64 +: 64];
      sb.push_back(b);
    end
    if (CS != 0 && count > 0) begin
      b.data = D'(cs);
      b.id   = '0;
      b.full = full;
      b.csum = 1'b1;
      b.last = 1'b1;
      sb.push_back(b);
    end
  endtask

  // Monitor / scoreboard consumer
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      out_model  = 0;
      stall_prev = 0;
      first_pend = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        hs_cyc     = cyc;
        first_pend = cmd_full_dump || (cmd_count != '0);
      end
      if (first_pend && m_axis_tvalid) begin
        chk("first_latency", longint'(cyc - hs_cyc), longint'(2 + L));
        first_pend = 0;
      end
      if (stall_prev) begin
        vectors++;
        if (!m_axis_tvalid || m_axis_tdata !== hold_data || m_axis_tuser !== hold_user ||
            m_axis_tlast !== hold_last) begin
          miscompares++;
          $display("FAIL stall_hold: tvalid=%0b tuser=%0h tlast=%0b want held tuser=%0h tlast=%0b",
                   m_axis_tvalid, m_axis_tuser, m_axis_tlast, hold_user, hold_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_beat: got beat tuser=%0h want none", m_axis_tuser);
        end else begin
          b = sb.pop_front();
          chk_wide("beat_tdata", m_axis_tdata, AXW'(b.data));
          chk_wide("beat_tuser", AXW'(m_axis_tuser), AXW'({46'b0, b.csum, b.full, b.id}));
          chk("beat_tlast", longint'(m_axis_tlast), longint'(b.last));
        end
        if (dump_beats == 0) first_id = int'(m_axis_tuser[15:0]);
        if (!m_axis_tuser[17]) begin
          last_row_id = int'(m_axis_tuser[15:0]);
          if (m_axis_tuser[15:0] == 16'd100) seen100 = 1;
        end else last_csum = m_axis_tdata[63:0];
        dump_beats++;
        exp_sent = exp_sent + 32'd1;
      end
      out_model = out_model + (bram_re ? 1 : 0) - ((m_axis_tvalid && m_axis_tready) ? 1 : 0);
      if (bram_re) chk("outstanding_le_max", longint'(out_model <= L + 2), 1);
      if (dump_done) done_cnt++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_data  = m_axis_tdata;
      hold_user  = m_axis_tuser;
      hold_last  = m_axis_tlast;
    end
  end

  task automatic wait_ready();
    for (int c = 0; c < 100 && !cmd_ready; c++) begin @(posedge clk); #1; end
  endtask

  task automatic run_dump(input vec_t v);
    int d0, budget, n;
    bit got;
    got = 0;
    wait_ready();
    d0 = done_cnt;
    dump_beats = 0;
    n = v.full ? R : v.count;
    push_exp(v.full, v.full ? 0 : v.start, n);
    cmd_valid = 1'b1; cmd_full_dump = v.full;
    cmd_start = AW'(v.start); cmd_count = (AW+1)'(v.count);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_full_dump = 1'b0;
    budget = 4 * n + 64;
    for (int c = 0; c < budget && !got; c++) begin
      m_axis_tready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (done_cnt != d0) got = 1;
    end
    m_axis_tready = 1'b1;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL dump_timeout: no dump_done in %0d cycles, want one", budget);
      sb.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("done_once", longint'(done_cnt - d0), 1);
    chk("sb_empty", longint'(sb.size()), 0);
    chk("beat_count", longint'(dump_beats), longint'(v.exp_beats));
    chk("first_id", longint'(first_id), longint'(v.exp_first));
    chk("last_row_id", longint'(last_row_id), longint'(v.exp_last));
    chk("beats_sent", longint'(beats_sent), longint'(exp_sent));
    chk("ready_after", longint'(cmd_ready), 1);
    chk("busy_after", longint'(busy), 0);
  endtask

  initial begin
    int d0;
    vec_t v;
    vecs[0] = '{1'b1,    5,    7, 1'b0, 2048 + CS,    0, 2047};
    vecs[1] = '{1'b0, 2046,    4, 1'b0,    4 + CS, 2046,    1};
    vecs[2] = '{1'b0,  300,   64, 1'b1,   64 + CS,  300,  363};
    vecs[3] = '{1'b0,    0,    1, 1'b0,    1 + CS,    0,    0};
    vecs[4] = '{1'b0, 2040,   16, 1'b1,   16 + CS, 2040,    7};
    vecs[5] = '{1'b0,   17, 2048, 1'b0, 2048 + CS,   17,   16};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", longint'(cmd_ready), 1);
    chk("rst_tvalid", longint'(m_axis_tvalid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_beats_sent", longint'(beats_sent), 0);
    chk("rst_dump_done", longint'(dump_done), 0);
    chk("rst_bram_re", longint'(bram_re), 0);
    chk("rst_tuser", longint'(m_axis_tuser), 0);
    chk("rst_tlast", longint'(m_axis_tlast), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_dump(vecs[i]);

    // zero-count partial dump
    wait_ready();
    d0 = done_cnt;
    dump_beats = 0;
    cmd_valid = 1'b1; cmd_full_dump = 1'b0; cmd_start = AW'(5); cmd_count = '0;
    @(negedge clk);
    chk("zero_hs_ready", longint'(cmd_ready), 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("zero_done_pulse", longint'(dump_done), 1);
    chk("zero_ready", longint'(cmd_ready), 1);
    chk("zero_busy", longint'(busy), 0);
    @(negedge clk);
    chk("zero_done_low", longint'(dump_done), 0);
    chk("zero_tvalid", longint'(m_axis_tvalid), 0);
    repeat (3) @(negedge clk);
    chk("zero_done_count", longint'(done_cnt - d0), 1);
    chk("zero_beats", longint'(dump_beats), 0);
    @(posedge clk); #1;

    // reset in the middle of a full dump
    seen100 = 0;
    dump_beats = 0;
    push_exp(1'b1, 0, R);
    cmd_valid = 1'b1; cmd_full_dump = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_full_dump = 1'b0;
    for (int c = 0; c < 400 && !seen100; c++) begin @(posedge clk); #1; end
    chk("mid_reached_row100", longint'(seen100), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    exp_sent = '0;
    d0 = done_cnt;
    @(negedge clk);
    chk("mid_rst_tvalid", longint'(m_axis_tvalid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_beats_sent", longint'(beats_sent), 0);
    chk("mid_rst_ready", longint'(cmd_ready), 1);
    repeat (4) @(negedge clk);
    chk("mid_rst_no_done", longint'(done_cnt - d0), 0);
    @(posedge clk); #1;
    v = '{1'b0, 10, 8, 1'b0, 8 + CS, 10, 17};
    run_dump(v);

`ifdef HTC_READBACK_CHECKSUM_EN
    pat = 1;
    v = '{1'b0, 0, 4, 1'b0, 5, 0, 3};
    run_dump(v);
    chk("csum_value", longint'(last_csum), longint'(64'hF));
    pat = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
